// File: rtl/bt_cmd_scheduler.sv
// Command scheduler between the UART receive path and the MP3 player control port.
// Buffers decoded bytes, arbitrates against button requests and expands track jumps.
module bt_cmd_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_TRACKS = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD_VALID,
    input  logic [7:0] RXD_DATA,
    input  logic       BTN_REQ,
    input  logic [1:0] BTN_OP,
    input  logic [2:0] CUR_TRACK,
    input  logic       CMD_READY,
    output logic       CMD_VALID,
    output logic [1:0] CMD_OP,
    output logic       FIFO_EMPTY,
    output logic       FIFO_FULL,
    output logic       SCHED_BUSY,
    output logic [7:0] DROP_CNT
);
    // Player handshake: an op transfers on any rising CLK edge where CMD_VALID
    // and CMD_READY are both high; CMD_OP holds while CMD_VALID waits for READY.
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NT = NUM_TRACKS;

    typedef enum logic [1:0] {IDLE, ISSUE, JCALC, JSTEP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cmd_op_q, cmd_op_d;
    logic [2:0]  cur_q, cur_d;
    logic [2:0]  tgt_q, tgt_d;
    logic [2:0]  step_q, step_d;
    logic        btn_pend_q, btn_pend_d;
    logic [1:0]  btn_op_q, btn_op_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [7:0]  drop_q, drop_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic       rx_ok, push, pop, drop, btn_serve, fifo_empty, fifo_full;
    logic [7:0] head;

    always_comb begin
        rx_ok      = RXD_VALID && (RXD_DATA >= 8'h01) && (RXD_DATA <= 8'h0B);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
        head       = mem_q[rd_ptr_q];
    end

    always_comb begin
        state_d   = state_q;
        cmd_op_d  = cmd_op_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        step_d    = step_q;
        pop       = 1'b0;
        btn_serve = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_pend_q) begin
                    cmd_op_d  = btn_op_q;
                    btn_serve = 1'b1;
                    state_d   = ISSUE;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head <= 8'h04) begin
                        // 0x01..0x04 map onto op codes 00..11
                        cmd_op_d = head[1:0] - 2'd1;
                        state_d  = ISSUE;
                    end else begin
                        cur_d   = CUR_TRACK;
                        tgt_d   = 3'(head - 8'h05);
                        state_d = JCALC;
                    end
                end
            end
            ISSUE: begin
                if (CMD_READY) state_d = IDLE;
            end
            JCALC: begin
                if (({29'd0, tgt_q} >= NT) || (tgt_q == cur_q)) begin
                    state_d = IDLE;
                end else if (tgt_q > cur_q) begin
                    step_d   = tgt_q - cur_q;
                    cmd_op_d = 2'b01;
                    state_d  = JSTEP;
                end else begin
                    step_d   = cur_q - tgt_q;
                    cmd_op_d = 2'b00;
                    state_d  = JSTEP;
                end
            end
            JSTEP: begin
                if (CMD_READY) begin
                    step_d = step_q - 3'd1;
                    if (step_q == 3'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push     = rx_ok && (!fifo_full || pop);
        drop     = rx_ok && fifo_full && !pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        drop_d   = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        // A request landing in the serve cycle becomes the next pending op
        btn_pend_d = btn_pend_q;
        btn_op_d   = btn_op_q;
        if (BTN_REQ) begin
            btn_pend_d = 1'b1;
            btn_op_d   = BTN_OP;
        end else if (btn_serve) begin
            btn_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cmd_op_q   <= 2'b00;
            cur_q      <= 3'd0;
            tgt_q      <= 3'd0;
            step_q     <= 3'd0;
            btn_pend_q <= 1'b0;
            btn_op_q   <= 2'b00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cmd_op_q   <= cmd_op_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            step_q     <= step_d;
            btn_pend_q <= btn_pend_d;
            btn_op_q   <= btn_op_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= RXD_DATA;
    end

    assign CMD_VALID  = (state_q == ISSUE) || (state_q == JSTEP);
    assign CMD_OP     = cmd_op_q;
    assign FIFO_EMPTY = fifo_empty;
    assign FIFO_FULL  = fifo_full;
    assign SCHED_BUSY = (state_q != IDLE);
    assign DROP_CNT   = drop_q;
endmodule
